processing_unit_ext: RTL

Parametrised next-generation datapath for the small stored-program CPU. It provides a register file of NUM_REGS words, PC, IR, address register, ALU operand register Y and a flag register (Z, C, N). The ALU includes a multi-cycle serial shifter, and memory reads stall on a mem_ready handshake. The block is driven cycle by cycle by the external control unit.

---
 rtl/processing_unit_pkg.sv | 40 ++++
 rtl/pu_alu_serial.sv | 101 ++++++++++
 rtl/processing_unit_ext.sv | 121 ++++++++++++
 3 files changed

// File: rtl/processing_unit_pkg.sv
// Shared definitions for the processing_unit_ext datapath:
//   - ALU opcode values (as decoded from the top OP_SIZE bits of IR)
//   - Bus_2 source select encodings
//   - flag register bit positions and a packing helper
package processing_unit_pkg;

  // ALU opcodes; every other value behaves as NOP.
  localparam int OP_NOP = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_XOR = 5;
  localparam int OP_NOT = 6;
  localparam int OP_SHL = 7;
  localparam int OP_SHR = 8;

  // Bus_2 source select.
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;
  localparam logic [1:0] SEL2_ZERO = 2'd3;

  // Flag register layout.
  localparam int NUM_FLAGS = 3;
  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_N    = 2;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic z, input logic c,
                                                      input logic n);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/pu_alu_serial.sv
// ALU for processing_unit_ext: combinational arithmetic/logic ops plus a
// serial shifter that moves one bit per cycle.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   a, b        operands (A = Y register, B = Bus_1)
//   opcode      ALU operation, taken from IR
//   flag_load   flag-load strobe (already blocked by the caller while busy)
//   result      ALU result (shift ops return the shift register once started)
//   flags       flag register, indexed by FLAG_Z / FLAG_C / FLAG_N
//   alu_busy    high while a serial shift is in progress
module pu_alu_serial
  import processing_unit_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [OP_SIZE-1:0]   opcode,
  input  logic                 flag_load,
  output logic [WORD_SIZE-1:0] result,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 alu_busy
);

  localparam int CW = $clog2(WORD_SIZE);

  logic [31:0]          op;
  logic                 is_shift;
  logic [CW-1:0]        amount;
  logic [CW-1:0]        count;
  logic [WORD_SIZE-1:0] shift_reg;
  logic                 shift_left;
  logic [WORD_SIZE-1:0] shift_next;
  logic                 shift_out;
  logic                 comb_c;

  assign op       = 32'(opcode);
  assign is_shift = (op == OP_SHL) || (op == OP_SHR);
  assign amount   = b[CW-1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    result = a;
    comb_c = 1'b0;
    case (op)
      OP_ADD: {comb_c, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: {comb_c, result} = {1'b0, a} - {1'b0, b};  // top bit is the borrow
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      // A zero-length shift is just A; otherwise the shifter owns the result.
      OP_SHL, OP_SHR: result = (amount == '0) ? a : shift_reg;
      default: result = a;
    endcase
  end

  // One-bit step of the shifter in the direction latched at start.
  always_comb begin
    if (shift_left) begin
      shift_next = {shift_reg[WORD_SIZE-2:0], 1'b0};
      shift_out  = shift_reg[WORD_SIZE-1];
    end else begin
      shift_next = {1'b0, shift_reg[WORD_SIZE-1:1]};
      shift_out  = shift_reg[0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      count      <= '0;
      shift_left <= 1'b0;
      alu_busy   <= 1'b0;
      flags      <= '0;
    end else if (alu_busy) begin
      shift_reg <= shift_next;
      count     <= count - CW'(1);
      if (count == CW'(1)) begin
        alu_busy <= 1'b0;
        flags    <= pack_flags(shift_next == '0, shift_out, shift_next[WORD_SIZE-1]);
      end
    end else if (flag_load) begin
      if (is_shift && amount != '0) begin
        shift_reg  <= a;
        count      <= amount;
        shift_left <= (op == OP_SHL);
        alu_busy   <= 1'b1;
      end else begin
        flags <= pack_flags(result == '0, comb_c, result[WORD_SIZE-1]);
      end
    end
  end

endmodule

// File: rtl/processing_unit_ext.sv
// Datapath of the stored-program CPU: register file, PC, IR, address
// register, ALU operand register Y, flags and the serial-shift ALU.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   mem_word       memory read data, mem_ready marks it valid
//   load_r         one-hot register-file write strobes from Bus_2
//   load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z  strobes
//   sel_bus_1      0..NUM_REGS-1 -> Rn, NUM_REGS -> PC, else 0
//   sel_bus_2      ALU result / Bus_1 / mem_word / zero
//   instruction    IR contents; address: address register contents
//   bus_1          current Bus_1 value
//   zflag, cflag, nflag  flag register
//   alu_busy       serial shift in progress (all loads and inc_pc ignored)
//   mem_stall      Bus_2 sources memory while mem_ready is low
module processing_unit_ext
  import processing_unit_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 4,
  parameter int OP_SIZE   = 4,
  parameter int SEL1_SIZE = $clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] mem_word,
  input  logic                 mem_ready,
  input  logic [NUM_REGS-1:0]  load_r,
  input  logic                 load_pc,
  input  logic                 inc_pc,
  input  logic                 load_ir,
  input  logic                 load_add_r,
  input  logic                 load_reg_y,
  input  logic                 load_reg_z,
  input  logic [SEL1_SIZE-1:0] sel_bus_1,
  input  logic [1:0]           sel_bus_2,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] bus_1,
  output logic                 zflag,
  output logic                 cflag,
  output logic                 nflag,
  output logic                 alu_busy,
  output logic                 mem_stall
);

  localparam int RW = $clog2(NUM_REGS);

  logic [WORD_SIZE-1:0] reg_file [NUM_REGS];
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] reg_y;
  logic [WORD_SIZE-1:0] bus_2;
  logic [WORD_SIZE-1:0] alu_result;
  logic [NUM_FLAGS-1:0] flags;
  logic                 bus2_wr_en;
  logic                 ctl_en;

  always_comb begin
    bus_1 = '0;
    if (int'(sel_bus_1) < NUM_REGS) begin
      bus_1 = reg_file[sel_bus_1[RW-1:0]];
    end else if (int'(sel_bus_1) == NUM_REGS) begin
      bus_1 = pc;
    end
  end

  always_comb begin
    case (sel_bus_2)
      SEL2_ALU:  bus_2 = alu_result;
      SEL2_BUS1: bus_2 = bus_1;
      SEL2_MEM:  bus_2 = mem_word;
      default:   bus_2 = '0;
    endcase
  end

  assign mem_stall  = (sel_bus_2 == SEL2_MEM) && !mem_ready;
  assign ctl_en     = !alu_busy;
  // Anything written from Bus_2 must wait for valid memory data.
  assign bus2_wr_en = ctl_en && !mem_stall;

  // NOTE: the register file is a small flop array, so it is cleared on reset
  // like every other architectural register (not inferred as a RAM).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
      pc          <= '0;
      instruction <= '0;
      address     <= '0;
      reg_y       <= '0;
    end else begin
      // Reads of bus_1 in this cycle see the pre-edge value of every register.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_r[i] && bus2_wr_en) reg_file[i] <= bus_2;
      end
      if (load_pc && bus2_wr_en) pc <= bus_2;
      else if (inc_pc && ctl_en) pc <= pc + WORD_SIZE'(1);
      if (load_ir && bus2_wr_en)    instruction <= bus_2;
      if (load_add_r && bus2_wr_en) address     <= bus_2;
      if (load_reg_y && bus2_wr_en) reg_y       <= bus_2;
    end
  end

  pu_alu_serial #(
    .WORD_SIZE(WORD_SIZE),
    .OP_SIZE  (OP_SIZE)
  ) u_alu (
    .clk      (clk),
    .rst      (rst),
    .a        (reg_y),
    .b        (bus_1),
    .opcode   (instruction[WORD_SIZE-1 -: OP_SIZE]),
    .flag_load(load_reg_z && ctl_en),
    .result   (alu_result),
    .flags    (flags),
    .alu_busy (alu_busy)
  );

  assign zflag = flags[FLAG_Z];
  assign cflag = flags[FLAG_C];
  assign nflag = flags[FLAG_N];

endmodule
